// File: rtl/intc_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// default source count and a lowest-index priority picker.
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } intc_state_e;

    localparam int N_SRC_DEFAULT = 4;

    // Lowest set index wins; an all-zero vector returns 0.
    function automatic logic [3:0] prio_first(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge capture of request levels into sticky pending bits.
// A set and a clear landing in the same cycle resolve in favour of the set.
module irq_edge_latch #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] pend
);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    always_comb begin
        prev_d = req;
        pend_d = (pend_q & ~clr) | (req & ~prev_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/interrupt_controller.sv
// Arbitrates pending device/NMI requests and runs the CPU acknowledge handshake.
//   state   | meaning
//   IDLE    | no service; pick NMI first, else lowest enabled pending source
//   REQ     | line asserted, waiting for respond=1
//   ACK     | line asserted, waiting for respond=0 (end of handler)
//   RELEASE | lines low for one cycle so the CPU can return to idle
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_req,
    input  logic             nmi_req,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             respond,
    output logic             interrupt,
    output logic             non_maskable_int,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic             in_service
);

    intc_state_e      state_q, state_d;
    logic             sel_nmi_q, sel_nmi_d;
    logic [ID_W-1:0]  sel_id_q, sel_id_d;
    logic             int_q, int_d;
    logic             nmi_q, nmi_d;
    logic             svc_q, svc_d;

    logic             nmi_pend;
    logic [N_SRC-1:0] clr_irq;
    logic             clr_nmi;
    logic [N_SRC-1:0] cand_vec;
    logic [ID_W-1:0]  cand_id;

    irq_edge_latch #(.WIDTH(N_SRC)) u_irq_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (irq_req),
        .clr   (clr_irq),
        .pend  (pending)
    );

    irq_edge_latch #(.WIDTH(1)) u_nmi_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (nmi_req),
        .clr   (clr_nmi),
        .pend  (nmi_pend)
    );

    assign cand_vec = pending & irq_mask;
    assign cand_id  = ID_W'(prio_first(16'(cand_vec)));

    always_comb begin
        state_d   = state_q;
        sel_nmi_d = sel_nmi_q;
        sel_id_d  = sel_id_q;
        int_d     = int_q;
        nmi_d     = nmi_q;
        svc_d     = svc_q;
        clr_irq   = '0;
        clr_nmi   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (nmi_pend) begin
                    state_d   = ST_REQ;
                    sel_nmi_d = 1'b1;
                    nmi_d     = 1'b1;
                    svc_d     = 1'b1;
                end else if (|cand_vec) begin
                    state_d   = ST_REQ;
                    sel_nmi_d = 1'b0;
                    sel_id_d  = cand_id;
                    int_d     = 1'b1;
                    svc_d     = 1'b1;
                end
            end
            ST_REQ: begin
                if (respond) state_d = ST_ACK;
            end
            ST_ACK: begin
                // Handler finished: retire the serviced request and drop the line.
                if (!respond) begin
                    state_d = ST_RELEASE;
                    int_d   = 1'b0;
                    nmi_d   = 1'b0;
                    svc_d   = 1'b0;
                    if (sel_nmi_q) clr_nmi = 1'b1;
                    else           clr_irq = N_SRC'(1) << sel_id_q;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_nmi_q <= 1'b0;
            sel_id_q  <= '0;
            int_q     <= 1'b0;
            nmi_q     <= 1'b0;
            svc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_nmi_q <= sel_nmi_d;
            sel_id_q  <= sel_id_d;
            int_q     <= int_d;
            nmi_q     <= nmi_d;
            svc_q     <= svc_d;
        end
    end

    assign interrupt        = int_q;
    assign non_maskable_int = nmi_q;
    assign irq_id           = sel_id_q;
    assign in_service       = svc_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: latency, priority, masking,
// re-pend, no-preemption and asynchronous reset behaviour.
module tb_interrupt_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_req;
    logic       nmi_req;
    logic [3:0] irq_mask;
    logic       respond;
    logic       interrupt;
    logic       non_maskable_int;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       in_service;

    int total = 0;
    int bad   = 0;

    interrupt_controller #(.N_SRC(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .irq_req          (irq_req),
        .nmi_req          (nmi_req),
        .irq_mask         (irq_mask),
        .respond          (respond),
        .interrupt        (interrupt),
        .non_maskable_int (non_maskable_int),
        .irq_id           (irq_id),
        .pending          (pending),
        .in_service       (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called with the line already asserted in REQ; runs one full handshake.
    task automatic serve(input string tag, input bit is_nmi, input logic [1:0] id);
        chk({tag, ".int"}, 32'(interrupt), is_nmi ? 32'd0 : 32'd1);
        chk({tag, ".nmi"}, 32'(non_maskable_int), is_nmi ? 32'd1 : 32'd0);
        if (!is_nmi) chk({tag, ".id"}, 32'(irq_id), 32'(id));
        chk({tag, ".svc"}, 32'(in_service), 32'd1);
        respond = 1'b1;
        tick();
        tick();
        chk({tag, ".hold"}, 32'(interrupt | non_maskable_int), 32'd1);
        respond = 1'b0;
        tick();
        chk({tag, ".drop"}, 32'({interrupt, non_maskable_int, in_service}), 32'd0);
        tick();
        chk({tag, ".release"}, 32'({interrupt, non_maskable_int}), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        irq_req  = 4'h0;
        nmi_req  = 1'b0;
        irq_mask = 4'h0;
        respond  = 1'b0;
        tick();
        tick();
        chk("reset.outs", 32'({interrupt, non_maskable_int, irq_id, pending, in_service}), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic maskable service of source 2
        irq_mask   = 4'hF;
        irq_req[2] = 1'b1;
        tick();
        chk("basic.pend", 32'(pending), 32'h4);
        chk("basic.early", 32'(interrupt), 32'd0);
        tick();
        irq_req[2] = 1'b0;
        chk("basic.int", 32'(interrupt), 32'd1);
        chk("basic.id", 32'(irq_id), 32'd2);
        respond = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("basic.hold", 32'(interrupt), 32'd1);
        respond = 1'b0;
        tick();
        chk("basic.drop", 32'(interrupt), 32'd0);
        chk("basic.clr", 32'(pending), 32'h0);
        tick();
        chk("basic.release", 32'(interrupt), 32'd0);
        tick();
        chk("basic.idle", 32'({interrupt, in_service}), 32'd0);

        // NMI, id 1 and id 3 all rise together
        irq_req = 4'b1010;
        nmi_req = 1'b1;
        tick();
        chk("prio.pend", 32'(pending), 32'ha);
        tick();
        irq_req = 4'h0;
        nmi_req = 1'b0;
        serve("prio.nmi", 1'b1, 2'd0);
        tick();
        serve("prio.id1", 1'b0, 2'd1);
        tick();
        serve("prio.id3", 1'b0, 2'd3);
        chk("prio.empty", 32'(pending), 32'h0);

        // masked source stays pending until enabled
        irq_mask   = 4'b1110;
        irq_req[0] = 1'b1;
        tick();
        tick();
        tick();
        chk("mask.noline", 32'(interrupt), 32'd0);
        chk("mask.pend", 32'(pending), 32'h1);
        irq_mask = 4'hF;
        tick();
        tick();
        irq_req[0] = 1'b0;
        serve("mask.id0", 1'b0, 2'd0);

        // source 1 re-requests in the same cycle respond falls
        irq_req[1] = 1'b1;
        tick();
        tick();
        irq_req[1] = 1'b0;
        chk("repend.int", 32'(interrupt), 32'd1);
        chk("repend.id", 32'(irq_id), 32'd1);
        respond = 1'b1;
        tick();
        tick();
        respond    = 1'b0;
        irq_req[1] = 1'b1;
        tick();
        chk("repend.drop", 32'(interrupt), 32'd0);
        chk("repend.pend", 32'(pending), 32'h2);
        tick();
        tick();
        irq_req[1] = 1'b0;
        serve("repend.again", 1'b0, 2'd1);
        chk("repend.empty", 32'(pending), 32'h0);

        // NMI during ACK of id 2 must wait
        irq_req[2] = 1'b1;
        tick();
        tick();
        irq_req[2] = 1'b0;
        chk("nopre.int", 32'(interrupt), 32'd1);
        respond = 1'b1;
        tick();
        nmi_req = 1'b1;
        tick();
        tick();
        chk("nopre.hold", 32'({interrupt, non_maskable_int}), 32'b10);
        respond = 1'b0;
        tick();
        chk("nopre.drop", 32'({interrupt, non_maskable_int}), 32'd0);
        tick();
        chk("nopre.gap", 32'(non_maskable_int), 32'd0);
        tick();
        nmi_req = 1'b0;
        serve("nopre.nmi", 1'b1, 2'd0);

        // asynchronous reset in the middle of a service
        irq_req[0] = 1'b1;
        tick();
        tick();
        chk("rst.int", 32'(interrupt), 32'd1);
        respond = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst.async", 32'({interrupt, non_maskable_int, irq_id, pending, in_service}), 32'd0);
        respond = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst.repend", 32'(pending), 32'h1);
        tick();
        serve("rst.id0", 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
